fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 47 ++++
 rtl/fetch_sequencer_pc.sv | 36 +++
 rtl/fetch_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, halt opcode
// and the opcode length-field decode used by the top level.
package fetch_pkg;

    typedef enum logic [1:0] {
        ADDR    = 2'b00,
        CAPTURE = 2'b01,
        SEND    = 2'b10,
        HALT    = 2'b11
    } fetch_state_e;

    // Widest byte the helpers below accept; opcodes are zero-extended to this.
    localparam int MAX_BYTE_W = 64;

    // All-ones opcode; callers slice off the low BYTE bits.
    localparam logic [MAX_BYTE_W-1:0] HALT_OPCODE = '1;

    // Operand count carried in the top clog2(max_bytes) opcode bits,
    // clamped so an instruction never exceeds max_bytes in total.
    function automatic int unsigned operand_count(
        input logic [MAX_BYTE_W-1:0] opcode,
        input int unsigned           byte_w,
        input int unsigned           max_bytes
    );
        int unsigned len_w;
        int unsigned field;
        len_w = $clog2(max_bytes);
        if (len_w == 0) begin
            return 0;
        end
        field = 32'(opcode >> (byte_w - len_w)) & ((32'd1 << len_w) - 32'd1);
        if (field > max_bytes - 1) begin
            field = max_bytes - 1;
        end
        return field;
    endfunction

    // Total instruction length in bytes (opcode plus operands).
    function automatic int unsigned length_field(
        input logic [MAX_BYTE_W-1:0] opcode,
        input int unsigned           byte_w,
        input int unsigned           max_bytes
    );
        return operand_count(opcode, byte_w, max_bytes) + 1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc.sv
// Wrapping program counter for the fetch sequencer. A load forces the
// reset address; an increment wraps from all-ones back to zero.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              load,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next pc: load has priority, increment wraps naturally at the top.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = RESET_ADDR;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // pc register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads variable-length instructions byte by
// byte from a synchronous memory and presents them, packed opcode-first,
// to a decoder with a start/ready handshake.
// Optional feature: define FETCH_SEQUENCER_HALT_EN to make the all-ones
// opcode stop the sequencer in HALT until reset.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                BYTE            = 8,
    parameter int                ADDR_W          = 8,
    parameter int                INSTR_MAX_BYTES = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR      = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [ADDR_W-1:0]                 pointer_for_memory,
    input  logic [BYTE-1:0]                   data_from_memory,
    output logic                              start_for_decoder,
    input  logic                              ready_from_decoder,
    output logic [BYTE*INSTR_MAX_BYTES-1:0]   data_for_decoder,
    output logic [$clog2(INSTR_MAX_BYTES+1)-1:0] length_for_decoder,
    output logic                              halted
);

    localparam int CNT_W  = $clog2(INSTR_MAX_BYTES + 1);
    localparam int DATA_W = BYTE * INSTR_MAX_BYTES;

    fetch_state_e state_q, state_d;

    logic [CNT_W-1:0]  idx_q, idx_d;          // byte index within instruction
    logic [CNT_W-1:0]  len_buf_q, len_buf_d;  // length of instruction being fetched
    logic [DATA_W-1:0] buf_q, buf_d;          // assembly buffer
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  len_q, len_d;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              pc_inc;
    logic              is_opcode;
    logic [CNT_W-1:0]  cur_len;
    logic [CNT_W-1:0]  idx_next;
    logic              last_byte;

    fetch_pc #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (RESET_ADDR)
    ) u_pc (
        .clk  (clk),
        .load (~reset),
        .inc  (pc_inc),
        .pc   (pc)
    );

    // Shared decode of the byte currently on the memory bus.
    assign pc_plus1  = pc + 1'b1;
    assign is_opcode = (idx_q == '0);
    assign cur_len   = is_opcode
                     ? CNT_W'(length_field(MAX_BYTE_W'(data_from_memory), BYTE, INSTR_MAX_BYTES))
                     : len_buf_q;
    assign idx_next  = idx_q + 1'b1;
    assign last_byte = (idx_next == cur_len);

`ifdef FETCH_SEQUENCER_HALT_EN
    logic halted_q, halted_d;
    logic capture_halt;

    // Halt only on an all-ones byte in the opcode slot.
    assign capture_halt = is_opcode && (data_from_memory == HALT_OPCODE[BYTE-1:0]);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ADDR:    state_d = CAPTURE;
            CAPTURE: begin
`ifdef FETCH_SEQUENCER_HALT_EN
                if (capture_halt) begin
                    state_d = HALT;
                end else
`endif
                if (last_byte) begin
                    state_d = SEND;
                end else begin
                    state_d = ADDR;
                end
            end
            SEND: begin
                if (ready_from_decoder) begin
                    state_d = ADDR;
                end
            end
`ifdef FETCH_SEQUENCER_HALT_EN
            HALT:    state_d = HALT;
`endif
            default: state_d = ADDR;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        idx_d     = idx_q;
        len_buf_d = len_buf_q;
        buf_d     = buf_q;
        ptr_d     = ptr_q;
        start_d   = start_q;
        data_d    = data_q;
        len_d     = len_q;
        pc_inc    = 1'b0;
`ifdef FETCH_SEQUENCER_HALT_EN
        halted_d  = halted_q;
`endif
        case (state_q)
            CAPTURE: begin
                pc_inc = 1'b1;
                idx_d  = idx_next;
                if (is_opcode) begin
                    buf_d     = '0;
                    len_buf_d = cur_len;
                end
                // Opcode lands in the top byte, operands in descending slots.
                for (int k = 0; k < INSTR_MAX_BYTES; k++) begin
                    if (idx_q == CNT_W'(INSTR_MAX_BYTES - 1 - k)) begin
                        buf_d[k*BYTE +: BYTE] = data_from_memory;
                    end
                end
`ifdef FETCH_SEQUENCER_HALT_EN
                if (capture_halt) begin
                    halted_d = 1'b1;
                end else
`endif
                if (last_byte) begin
                    start_d = 1'b1;
                    data_d  = buf_d;
                    len_d   = cur_len;
                end else begin
                    ptr_d = pc_plus1;
                end
            end
            SEND: begin
                if (ready_from_decoder) begin
                    start_d = 1'b0;
                    idx_d   = '0;
                    ptr_d   = pc;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q     <= '0;
            len_buf_q <= '0;
            buf_q     <= '0;
            ptr_q     <= RESET_ADDR;
            start_q   <= 1'b0;
            data_q    <= '0;
            len_q     <= '0;
`ifdef FETCH_SEQUENCER_HALT_EN
            halted_q  <= 1'b0;
`endif
        end else begin
            idx_q     <= idx_d;
            len_buf_q <= len_buf_d;
            buf_q     <= buf_d;
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            data_q    <= data_d;
            len_q     <= len_d;
`ifdef FETCH_SEQUENCER_HALT_EN
            halted_q  <= halted_d;
`endif
        end
    end

    assign pointer_for_memory = ptr_q;
    assign start_for_decoder  = start_q;
    assign data_for_decoder   = data_q;
    assign length_for_decoder = len_q;
`ifdef FETCH_SEQUENCER_HALT_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule
